gsim_mat_mem_server: RTL and testbench

// - Responder side of the GSIM matrix-memory read interface. It holds the packed matrix rows:
//   per matrix, 16 rows of A plus one row of b, 256 bits each.
// - Accepts row read requests from the solver and returns rows after a fixed latency.
// - Sits between the host/testbench load path and the GSIM core.
// - Supports optional pseudo-random ready stalls, to stress the solver's dout_vld handling.

---
 rtl/gsim_mat_mem_server.sv | 120 ++++++++++++
 tb/tb_gsim_mat_mem_server.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gsim_mat_mem_server.sv
//------------------------------------------------------------------------------
// Module      : gsim_mat_mem_server
// Description : Row store for the GSIM matrix memory. Host writes 256-bit rows;
//               the solver reads them back through a fixed-latency pipe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gsim_mat_mem_server #(
  parameter int         DEPTH     = 1024,
  parameter int         READ_LAT  = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_wr_en,
  input  logic [9:0]   i_wr_addr,
  input  logic [255:0] i_wr_data,
  input  logic         i_stall_mode,
  input  logic         i_mem_rreq,
  input  logic [9:0]   i_mem_addr,
  output logic         o_mem_rrdy,
  output logic [255:0] o_mem_dout,
  output logic         o_mem_dout_vld,
  output logic         o_err
);

  localparam int         c_stages = READ_LAT - 1;
  localparam logic [10:0] c_depth = 11'(DEPTH);

  logic [255:0] r_mem [DEPTH];
  logic [7:0]   r_lfsr;
  logic         w_lfsr_fb;
  logic         w_stall;
  logic         w_accept;
  logic         w_rd_oor;
  logic         w_wr_oor;
  logic         w_last_vld;
  logic [9:0]   w_last_addr;
  logic         w_last_oor;

  // Taps x^8+x^6+x^5+x^4+1 on a left-shifting register.
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_stall    = i_stall_mode & (r_lfsr[1:0] == 2'b00);
  assign o_mem_rrdy = ~i_reset & ~i_wr_en & ~w_stall;
  assign w_accept   = i_mem_rreq & o_mem_rrdy;
  assign w_rd_oor   = {1'b0, i_mem_addr} >= c_depth;
  assign w_wr_oor   = {1'b0, i_wr_addr} >= c_depth;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_err <= 1'b0;
    end else if ((w_accept & w_rd_oor) | (i_wr_en & w_wr_oor)) begin
      o_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !w_wr_oor) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  generate
    if (c_stages == 0) begin : g_no_pipe
      assign w_last_vld  = w_accept;
      assign w_last_addr = i_mem_addr;
    end else begin : g_pipe
      logic [c_stages-1:0]      r_vld;
      logic [c_stages-1:0][9:0] r_addr;

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= w_accept;
          for (int i = 1; i < c_stages; i++) begin
            r_vld[i] <= r_vld[i-1];
          end
        end
      end

      always_ff @(posedge i_clk) begin
        r_addr[0] <= i_mem_addr;
        for (int i = 1; i < c_stages; i++) begin
          r_addr[i] <= r_addr[i-1];
        end
      end

      assign w_last_vld  = r_vld[c_stages-1];
      assign w_last_addr = r_addr[c_stages-1];
    end
  endgenerate

  assign w_last_oor = {1'b0, w_last_addr} >= c_depth;

  // Output register doubles as the array read register; data holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mem_dout_vld <= 1'b0;
      o_mem_dout     <= '0;
    end else begin
      o_mem_dout_vld <= w_last_vld;
      if (w_last_vld) begin
        o_mem_dout <= w_last_oor ? '0 : r_mem[w_last_addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gsim_mat_mem_server.sv
//------------------------------------------------------------------------------
// Module      : tb_gsim_mat_mem_server
// Description : Directed self-checking bench for gsim_mat_mem_server.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_gsim_mat_mem_server;

  localparam int c_depth = 640;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [255:0] wr_data;
  logic         stall_mode;
  logic         rreq;
  logic [9:0]   addr;
  logic         rrdy;
  logic [255:0] dout;
  logic         dout_vld;
  logic         err;

  gsim_mat_mem_server #(
    .DEPTH    (c_depth),
    .READ_LAT (2),
    .LFSR_SEED(8'hA5)
  ) u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_wr_en       (wr_en),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_stall_mode  (stall_mode),
    .i_mem_rreq    (rreq),
    .i_mem_addr    (addr),
    .o_mem_rrdy    (rrdy),
    .o_mem_dout    (dout),
    .o_mem_dout_vld(dout_vld),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_vld    = 0;

  logic [255:0] m_mem [1024];
  logic [7:0]   m_lfsr = 8'hA5;
  logic         m_pend_vld = 1'b0;
  logic [255:0] m_pend_data = '0;
  logic         m_vld = 1'b0;
  logic [255:0] m_dout = '0;
  logic         m_err = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] row_pat(input int r);
    logic [15:0] v;
    v = r[15:0];
    return {16{v}};
  endfunction

  // One clock: check rrdy before the edge, advance the model, check outputs after.
  task automatic cycle();
    logic         exp_rrdy;
    logic         acc;
    logic         rst_s;
    logic [255:0] rd_data;
    logic         err_set;
    #1;
    exp_rrdy = !reset && !wr_en && !(stall_mode && (m_lfsr[1:0] == 2'b00));
    check("rrdy", {255'b0, rrdy}, {255'b0, exp_rrdy});
    acc     = rreq && exp_rrdy;
    rst_s   = reset;
    rd_data = (addr >= 10'(c_depth)) ? '0 : m_mem[addr];
    err_set = (acc && (addr >= 10'(c_depth))) || (wr_en && (wr_addr >= 10'(c_depth)));
    if (wr_en && (wr_addr < 10'(c_depth))) m_mem[wr_addr] = wr_data;
    if (acc) n_acc++;
    @(posedge clk);
    #1;
    if (rst_s) begin
      m_vld      = 1'b0;
      m_dout     = '0;
      m_pend_vld = 1'b0;
      m_err      = 1'b0;
      m_lfsr     = 8'hA5;
    end else begin
      m_vld = m_pend_vld;
      if (m_vld) m_dout = m_pend_data;
      m_pend_vld  = acc;
      m_pend_data = rd_data;
      if (err_set) m_err = 1'b1;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    if (dout_vld === 1'b1) n_vld++;
    check("vld", {255'b0, dout_vld}, {255'b0, m_vld});
    check("dout", dout, m_dout);
    check("err", {255'b0, err}, {255'b0, m_err});
  endtask

  task automatic rd(input int a);
    rreq = 1'b1;
    addr = 10'(a);
    cycle();
    rreq = 1'b0;
  endtask

  task automatic wr(input int a, input logic [255:0] d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    int acc0;
    int vld0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    stall_mode = 1'b0; rreq = 1'b0; addr = '0;
    repeat (2) cycle();
    reset = 1'b0;

    for (int r = 0; r < 17; r++) wr(r, row_pat(r));

    // single read, then idle so the lone pulse and the hold are visible
    rd(5);
    repeat (3) cycle();

    for (int a = 0; a < 17; a++) begin
      rreq = 1'b1;
      addr = 10'(a);
      cycle();
    end
    rreq = 1'b0;
    repeat (3) cycle();

    // host write and solver read collide on the same row
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = {8{32'hC0FFEE01}};
    rreq = 1'b1; addr = 10'd3;
    cycle();
    wr_en = 1'b0;
    cycle();
    rreq = 1'b0;
    repeat (3) cycle();

    stall_mode = 1'b1;
    acc0 = n_acc;
    vld0 = n_vld;
    for (int i = 0; i < 200; i++) begin
      rreq = 1'b1;
      addr = 10'(i % 17);
      cycle();
    end
    rreq = 1'b0;
    stall_mode = 1'b0;
    repeat (3) cycle();
    check("acc_vs_vld", 256'(n_vld - vld0), 256'(n_acc - acc0));

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wr(138, row_pat(138));
    wr(650, {256{1'b1}});
    rd(10);
    rd(138);
    rd(650);
    rd(700);
    repeat (3) cycle();

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rd(1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (4) cycle();

    stall_mode = 1'b1;
    rreq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr = 10'(i);
      cycle();
    end
    rreq = 1'b0;
    stall_mode = 1'b0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
